mem_b_arbiter: RTL

Arbiter for port B of the dual-port instruction/data memory. Port B returns the top-of-stack memory operand (T_m) to the CPU and is shared with the SNN engine's weight/state accessor. The arbiter grants one requester per cycle and tags each granted read. It routes the 1-cycle-latency read data back to the owner. A starvation guard bounds SNN wait time. Port A (instruction fetch) is not touched.

---
 rtl/mem_b_arbiter_pkg.sv | 33 +++
 rtl/mem_b_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_b_arbiter_pkg.sv
// Shared types for the port-B arbiter: read-owner tag, counter width and the
// fixed-priority grant decision.
package mem_b_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SNN  = 2'd2
  } owner_e;

  localparam int STARVE_W = 4;

  // Picks the single winner of port B for this cycle. A held lock excludes the
  // CPU outright, even in a cycle where the SNN has already dropped its request.
  function automatic owner_e arbitrate(input logic locked,
                                       input logic starved,
                                       input logic cpu_req,
                                       input logic snn_req);
    owner_e winner;
    winner = OWN_NONE;
    if (locked) begin
      if (snn_req) winner = OWN_SNN;
    end else if (starved && snn_req) begin
      winner = OWN_SNN;
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else if (snn_req) begin
      winner = OWN_SNN;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_b_arbiter.sv
// Port-B arbiter: shares the data port between the CPU (T_m operand) and the
// SNN accessor, with a burst lock, a starvation guard and tagged read return.
module mem_b_arbiter
  import mem_b_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,

  input  logic                  snn_req,
  input  logic                  snn_we,
  input  logic [ADDR_WIDTH-1:0] snn_addr,
  input  logic [DATA_WIDTH-1:0] snn_wdata,
  input  logic                  snn_lock,
  output logic                  snn_gnt,
  output logic                  snn_rvalid,
  output logic [DATA_WIDTH-1:0] snn_rdata,

  output logic                  mem_b_en,
  output logic                  mem_b_we,
  output logic [ADDR_WIDTH-1:0] mem_b_addr,
  output logic [DATA_WIDTH-1:0] mem_b_din,
  input  logic [DATA_WIDTH-1:0] mem_b_dout
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic                lock_q;
  logic [STARVE_W-1:0] starve_cnt;
  owner_e              rd_own_q;
  owner_e              winner;

  assign winner    = arbitrate(lock_q, starve_cnt == LIMIT, cpu_req, snn_req);
  assign cpu_gnt   = (winner == OWN_CPU);
  assign snn_gnt   = (winner == OWN_SNN);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // NOTE: every output of a combinational block gets a default on entry so a
  // missing branch can never infer a latch.
  always_comb begin
    mem_b_en   = 1'b0;
    mem_b_we   = 1'b0;
    mem_b_addr = '0;
    mem_b_din  = '0;
    unique case (winner)
      OWN_CPU: begin
        mem_b_en   = 1'b1;
        mem_b_we   = cpu_we;
        mem_b_addr = cpu_addr;
        mem_b_din  = cpu_wdata;
      end
      OWN_SNN: begin
        mem_b_en   = 1'b1;
        mem_b_we   = snn_we;
        mem_b_addr = snn_addr;
        mem_b_din  = snn_wdata;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      starve_cnt <= '0;
      rd_own_q   <= OWN_NONE;
    end else begin
      if (snn_gnt)       lock_q <= snn_lock;
      else if (!snn_req) lock_q <= 1'b0;

      if (snn_gnt || !snn_req)  starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;

      // Only reads expect data back; writes and idle cycles leave no owner.
      rd_own_q <= (mem_b_en && !mem_b_we) ? winner : OWN_NONE;
    end
  end

  assign cpu_rvalid = (rd_own_q == OWN_CPU);
  assign snn_rvalid = (rd_own_q == OWN_SNN);
  assign cpu_rdata  = mem_b_dout;
  assign snn_rdata  = mem_b_dout;

endmodule
